// File: rtl/fitness_wb_buffer.sv
// Population writeback buffer behind the fitness evaluator: stores scored individuals,
// tracks the minimum-energy elite, flags generation completion and serves a registered read port.
module fitness_wb_buffer #(
    parameter int PARTICLE_LENGTH   = 2,
    parameter int LATTICE_LENGTH    = 11,
    parameter int INDIVIDUAL_LENGTH = LATTICE_LENGTH * PARTICLE_LENGTH,
    parameter int SELF_FIT_LENGTH   = 10,
    parameter int POP_SIZE          = 50,
    parameter int IDX_WIDTH         = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         in_valid_i,
    input  logic [SELF_FIT_LENGTH-1:0]   total_energy_i,
    input  logic [INDIVIDUAL_LENGTH-1:0] individual_vec_i,
    input  logic [IDX_WIDTH-1:0]         ind_wb_idx_i,
    input  logic                         gen_start_i,
    input  logic                         rd_en_i,
    input  logic [IDX_WIDTH-1:0]         rd_idx_i,
    output logic                         rd_valid_ff_o,
    output logic [SELF_FIT_LENGTH-1:0]   rd_energy_ff_o,
    output logic [INDIVIDUAL_LENGTH-1:0] rd_individual_ff_o,
    output logic                         best_valid_ff_o,
    output logic [SELF_FIT_LENGTH-1:0]   best_energy_ff_o,
    output logic [IDX_WIDTH-1:0]         best_idx_ff_o,
    output logic [INDIVIDUAL_LENGTH-1:0] best_individual_ff_o,
    output logic [IDX_WIDTH-1:0]         wr_count_ff_o,
    output logic                         gen_done_ff_o,
    output logic                         err_ff_o
);

    localparam int SLOT_W = (POP_SIZE > 1) ? $clog2(POP_SIZE) : 1;
    localparam logic [IDX_WIDTH-1:0] POP_LIMIT = IDX_WIDTH'(POP_SIZE);

    typedef enum logic {
        COLLECT,
        READY
    } state_t;

    state_t state, state_next;

    logic [SELF_FIT_LENGTH-1:0]   energy_mem [POP_SIZE];
    logic [INDIVIDUAL_LENGTH-1:0] vec_mem    [POP_SIZE];

    logic [POP_SIZE-1:0]          slot_valid, slot_valid_next;
    logic [IDX_WIDTH-1:0]         wr_count, wr_count_next;
    logic                         err, err_next;
    logic                         best_valid, best_valid_next;
    logic [SELF_FIT_LENGTH-1:0]   best_energy, best_energy_next;
    logic [IDX_WIDTH-1:0]         best_idx, best_idx_next;
    logic [INDIVIDUAL_LENGTH-1:0] best_individual, best_individual_next;

    logic                         accept;
    logic                         dup;
    logic                         wr_in_range;
    logic                         rd_in_range;
    logic [SLOT_W-1:0]            wr_slot;
    logic [SLOT_W-1:0]            rd_slot;

    assign wr_slot     = ind_wb_idx_i[SLOT_W-1:0];
    assign rd_slot     = rd_idx_i[SLOT_W-1:0];
    assign wr_in_range = ind_wb_idx_i < POP_LIMIT;
    assign rd_in_range = rd_idx_i < POP_LIMIT;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // gen_start clears first, so a same-cycle write lands as the first entry of the new generation
    always_comb begin
        slot_valid_next      = gen_start_i ? '0 : slot_valid;
        wr_count_next        = gen_start_i ? '0 : wr_count;
        err_next             = gen_start_i ? 1'b0 : err;
        best_valid_next      = gen_start_i ? 1'b0 : best_valid;
        best_energy_next     = gen_start_i ? '1 : best_energy;
        best_idx_next        = best_idx;
        best_individual_next = best_individual;

        accept = in_valid_i && wr_in_range && (gen_start_i || state == COLLECT);
        dup    = accept && slot_valid_next[wr_slot];

        if (in_valid_i && !accept) begin
            err_next = 1'b1;
        end

        if (accept) begin
            slot_valid_next[wr_slot] = 1'b1;
            if (dup) begin
                err_next = 1'b1;
            end else if (wr_count_next < POP_LIMIT) begin
                wr_count_next = wr_count_next + IDX_WIDTH'(1);
            end
            if (!best_valid_next || (total_energy_i < best_energy_next)) begin
                best_valid_next      = 1'b1;
                best_energy_next     = total_energy_i;
                best_idx_next        = ind_wb_idx_i;
                best_individual_next = individual_vec_i;
            end
        end

        state_next = (wr_count_next == POP_LIMIT) ? READY : COLLECT;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_valid      <= '0;
            wr_count        <= '0;
            err             <= 1'b0;
            best_valid      <= 1'b0;
            best_energy     <= '1;
            best_idx        <= '0;
            best_individual <= '0;
        end else begin
            slot_valid      <= slot_valid_next;
            wr_count        <= wr_count_next;
            err             <= err_next;
            best_valid      <= best_valid_next;
            best_energy     <= best_energy_next;
            best_idx        <= best_idx_next;
            best_individual <= best_individual_next;
        end
    end

    // Payload storage is left unreset; the valid bits alone decide what is visible
    always_ff @(posedge clk_i) begin
        if (accept) begin
            energy_mem[wr_slot] <= total_energy_i;
            vec_mem[wr_slot]    <= individual_vec_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_valid_ff_o      <= 1'b0;
            rd_energy_ff_o     <= '0;
            rd_individual_ff_o <= '0;
        end else begin
            rd_valid_ff_o <= rd_en_i;
            if (rd_en_i) begin
                if (rd_in_range && slot_valid[rd_slot]) begin
                    rd_energy_ff_o     <= energy_mem[rd_slot];
                    rd_individual_ff_o <= vec_mem[rd_slot];
                end else begin
                    rd_energy_ff_o     <= '0;
                    rd_individual_ff_o <= '0;
                end
            end
        end
    end

    assign best_valid_ff_o      = best_valid;
    assign best_energy_ff_o     = best_energy;
    assign best_idx_ff_o        = best_idx;
    assign best_individual_ff_o = best_individual;
    assign wr_count_ff_o        = wr_count;
    assign gen_done_ff_o        = (state == READY);
    assign err_ff_o             = err;

endmodule

// File: doc/fitness_wb_buffer.md
Name: fitness_wb_buffer

Overview:
- Sits directly downstream of the fitness evaluation pipeline.
- Captures each scored individual (vector, total energy, writeback index) into a population-sized register file.
- Tracks the minimum-energy (elite) individual of the current generation.
- Raises a generation-complete flag once every population slot is written, and provides a 1-cycle-latency read port for the selection/crossover stage.

Parameters:
PARTICLE_LENGTH, 2, bits per lattice site
LATTICE_LENGTH, 11, sites per individual
INDIVIDUAL_LENGTH, LATTICE_LENGTH*PARTICLE_LENGTH, individual vector width
SELF_FIT_LENGTH, 10, total energy width
POP_SIZE, 50, population entries
IDX_WIDTH, 8, index width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-high reset
in_valid_i  in  1  scored individual present (from evaluator out_valid)
total_energy_i  in  SELF_FIT_LENGTH  energy of incoming individual
individual_vec_i  in  INDIVIDUAL_LENGTH  incoming individual
ind_wb_idx_i  in  IDX_WIDTH  destination slot
gen_start_i  in  1  pulse: clear buffer, begin new generation
rd_en_i  in  1  read request
rd_idx_i  in  IDX_WIDTH  read slot
rd_valid_ff_o  out  1  read data valid
rd_energy_ff_o  out  SELF_FIT_LENGTH  read energy
rd_individual_ff_o  out  INDIVIDUAL_LENGTH  read individual
best_valid_ff_o  out  1  elite registers hold a written entry
best_energy_ff_o  out  SELF_FIT_LENGTH  minimum energy this generation
best_idx_ff_o  out  IDX_WIDTH  slot of elite
best_individual_ff_o  out  INDIVIDUAL_LENGTH  elite vector
wr_count_ff_o  out  IDX_WIDTH  distinct slots written
gen_done_ff_o  out  1  all POP_SIZE slots written (level)
err_ff_o  out  1  sticky protocol error

Behaviour:
- Reset (async, rst_i=1):
  - FSM=COLLECT; all valid bits, counts, read outputs, best_idx, best_individual, gen_done and err = 0.
  - best_energy_ff_o = all ones. Storage contents need not be cleared.
- FSM states:
  - COLLECT: accepts writes.
  - READY: gen_done_ff_o=1; writes rejected.
  - COLLECT->READY on the cycle after an accepted write brings wr_count to POP_SIZE.
  - READY->COLLECT on gen_start_i.
- Write acceptance: in_valid_i=1 in COLLECT and ind_wb_idx_i<POP_SIZE.
  - Slot stores energy and vector.
  - Slot valid bit set.
  - wr_count increments only if the slot was previously invalid.
- Duplicate index (slot already valid): data overwritten, count unchanged, err_ff_o set.
- Rejected write: in_valid_i with idx>=POP_SIZE, or in_valid_i in READY (without gen_start_i). Storage and count untouched, err_ff_o set.
- Elite update on accepted write:
  - Replace elite if best_valid_ff_o=0 or total_energy_i < best_energy_ff_o, strictly unsigned less-than.
  - Ties keep the earlier entry.
  - Elite is not recomputed when a slot is overwritten.
  - Elite outputs update 1 cycle after the write.
- gen_start_i, any state:
  - Next cycle: valid bits, wr_count, best_valid, gen_done, err cleared; best_energy = all ones; FSM=COLLECT.
  - A same-cycle in_valid_i is applied after the clear: it becomes the first entry of the new generation, count=1, elite=that entry.
- Read port:
  - rd_en_i sampled at edge N; at N+1 rd_valid_ff_o=1 with slot contents. Valid in every state.
  - rd_idx_i>=POP_SIZE or slot invalid: rd_valid_ff_o=1, data outputs 0.
  - Read and write to the same slot in the same cycle returns pre-write data.
  - rd_en_i=0: rd_valid_ff_o=0 next cycle, data outputs hold last value.
- Throughput: one write and one read per cycle, no backpressure. The evaluator has no stall input, so the buffer never stalls it.
- Widths:
  - Energy compare is unsigned on SELF_FIT_LENGTH bits.
  - wr_count saturates at POP_SIZE.
  - POP_SIZE must be <= 2^IDX_WIDTH - 1.
- Mid-operation reset: all state returns to reset values immediately. Partially collected generation is discarded.

Test Plan:
- POP_SIZE=4: writes idx 0..3, energies 9,5,7,5 (back-to-back).
  - Expect best_energy=5, best_idx=1 (tie keeps first).
  - wr_count=4; gen_done_ff_o=1 the cycle after the 4th write.
  - err=0.
- After the above, rd_en with idx 2 -> next cycle rd_valid=1, rd_energy=7, correct vector.
  - rd_idx=6 -> rd_valid=1, data 0.
  - Same-cycle read/write of idx 3 returns old data.
- Error cases:
  - Write idx 2 twice (energy 8 then 3) -> count unchanged, slot holds 3, elite=3, err=1.
  - In READY, write idx 0 -> rejected, err=1, contents unchanged.
  - Write idx 9 (>=POP_SIZE) -> rejected, err=1.
- gen_start_i with simultaneous write idx 1, energy 12 -> next cycle gen_done=0, err=0, count=1, best_energy=12, best_idx=1.
- rst_i asserted asynchronously mid-generation (count=2) -> outputs immediately at reset values, best_energy all ones.
  - After release, collection restarts from count 0.
- Energy extremes: write energy 1023 first, then 0 -> elite updates to 0.
  - Single write of 1023 as the only entry still sets best_valid=1, best_energy=1023.
